// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  Module   : free_list
//  Purpose  : Physical-register free list for the rename stage. A circular
//             RAM of free register numbers with a speculative head (allocation
//             side), a committed head (retirement side) and a tail (free side).
//             A flush snaps the speculative head back to the committed head,
//             rolling back all uncommitted allocations in a single cycle.
//
//  Ports    : clk            - clock
//             rst            - asynchronous reset, active-high
//             alloc_req_i    - per-slot allocation request
//             alloc_fire_i   - decode group advances; consume requests
//             alloc_ready_o  - enough free entries for all requesting slots
//             preg_o         - register number offered to each slot
//             commit_dest_i  - committing slot had allocated a destination
//             free_i         - committing slot releases free_preg_i
//             free_preg_i    - previous-mapping register to release
//             restore_i      - flush; discard uncommitted allocations
//             free_cnt_o     - registered count of free entries
//             err_o          - sticky protocol-error flag
//
//  Options  : FREELIST_CHECK_EN - when defined, protocol checking drives a
//             sticky err_o and simulation assertions; otherwise err_o is 0.
//             DECODE_WIDTH / COMMIT_WIDTH set the default slot counts (4).
//
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef DECODE_WIDTH
    `define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
    `define COMMIT_WIDTH 4
`endif

module free_list #(
    parameter int   PHY_REG_NUM = 64,
    parameter int   ALLOC_WIDTH = `DECODE_WIDTH,
    parameter int   FREE_WIDTH  = `COMMIT_WIDTH,
    localparam int  PW          = $clog2(PHY_REG_NUM)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ALLOC_WIDTH-1:0]            alloc_req_i,
    input  logic                              alloc_fire_i,
    output logic                              alloc_ready_o,
    output logic [ALLOC_WIDTH-1:0][PW-1:0]    preg_o,
    input  logic [FREE_WIDTH-1:0]             commit_dest_i,
    input  logic [FREE_WIDTH-1:0]             free_i,
    input  logic [FREE_WIDTH-1:0][PW-1:0]     free_preg_i,
    input  logic                              restore_i,
    output logic [PW:0]                       free_cnt_o,
    output logic                              err_o
);

    localparam logic [PW:0] C_DEPTH = (PW+1)'(PHY_REG_NUM);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] ram_q [PHY_REG_NUM];
    logic [PW:0]   spec_head_q, spec_head_d;
    logic [PW:0]   cmt_head_q,  cmt_head_d;
    logic [PW:0]   tail_q,      tail_d;
    logic [PW:0]   free_cnt_q,  free_cnt_d;

    // ------------------------------------------------------------------
    // Population counts; the prefix counts compact the sparse slot masks
    // onto consecutive FIFO positions.
    // ------------------------------------------------------------------
    logic [PW:0]   w_alloc_pre [ALLOC_WIDTH];
    logic [PW:0]   w_alloc_cnt;
    logic [PW:0]   w_free_pre  [FREE_WIDTH];
    logic [PW:0]   w_free_cnt;
    logic [PW:0]   w_cmt_cnt;
    logic [PW-1:0] w_rd_idx    [ALLOC_WIDTH];
    logic [PW-1:0] w_wr_idx    [FREE_WIDTH];
    logic          w_pop;

    always_comb begin
        w_alloc_cnt = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            w_alloc_pre[i] = w_alloc_cnt;
            w_alloc_cnt    = w_alloc_cnt + {{PW{1'b0}}, alloc_req_i[i]};
        end
    end

    always_comb begin
        w_free_cnt = '0;
        w_cmt_cnt  = '0;
        for (int k = 0; k < FREE_WIDTH; k++) begin
            w_free_pre[k] = w_free_cnt;
            w_free_cnt    = w_free_cnt + {{PW{1'b0}}, free_i[k]};
            w_cmt_cnt     = w_cmt_cnt  + {{PW{1'b0}}, commit_dest_i[k]};
        end
    end

    // ------------------------------------------------------------------
    // Allocation side. Readiness uses only the registered count, so
    // entries freed this cycle are not offered until the next one.
    // ------------------------------------------------------------------
    assign alloc_ready_o = (free_cnt_q >= w_alloc_cnt);

    always_comb begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            w_rd_idx[i] = spec_head_q[PW-1:0] + w_alloc_pre[i][PW-1:0];
            preg_o[i]   = ram_q[w_rd_idx[i]];
        end
    end

    always_comb begin
        for (int k = 0; k < FREE_WIDTH; k++) begin
            w_wr_idx[k] = tail_q[PW-1:0] + w_free_pre[k][PW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state pointers. Restore takes the committed head after this
    // cycle's commit increment and overrides any allocation.
    // ------------------------------------------------------------------
    assign w_pop = alloc_fire_i & alloc_ready_o & ~restore_i;

    always_comb begin
        cmt_head_d = cmt_head_q + w_cmt_cnt;
        tail_d     = tail_q + w_free_cnt;
        if (restore_i) begin
            spec_head_d = cmt_head_d;
        end else if (w_pop) begin
            spec_head_d = spec_head_q + w_alloc_cnt;
        end else begin
            spec_head_d = spec_head_q;
        end
        free_cnt_d = tail_d - spec_head_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHY_REG_NUM; i++) begin
                ram_q[i] <= PW'(i);
            end
            spec_head_q <= '0;
            cmt_head_q  <= '0;
            tail_q      <= C_DEPTH;
            free_cnt_q  <= C_DEPTH;
        end else begin
            for (int k = 0; k < FREE_WIDTH; k++) begin
                if (free_i[k]) begin
                    ram_q[w_wr_idx[k]] <= free_preg_i[k];
                end
            end
            spec_head_q <= spec_head_d;
            cmt_head_q  <= cmt_head_d;
            tail_q      <= tail_d;
            free_cnt_q  <= free_cnt_d;
        end
    end

    assign free_cnt_o = free_cnt_q;

    // ------------------------------------------------------------------
    // Protocol checking
    // ------------------------------------------------------------------
`ifdef FREELIST_CHECK_EN
    logic        err_q;
    logic        w_err_fire;
    logic        w_err_over;
    logic        w_err_pass;
    logic        w_err_dup;
    logic [PW:0] w_inflight;

    assign w_err_fire = alloc_fire_i & ~alloc_ready_o;
    assign w_err_over = (|free_i) & (free_cnt_d > C_DEPTH);
    // Uncommitted allocations can never exceed the depth; a larger
    // modular distance means the committed head overtook spec_head.
    assign w_inflight = spec_head_d - cmt_head_d;
    assign w_err_pass = (w_inflight > C_DEPTH);

    always_comb begin
        w_err_dup = 1'b0;
        for (int a = 0; a < FREE_WIDTH; a++) begin
            for (int b = a + 1; b < FREE_WIDTH; b++) begin
                if (free_i[a] && free_i[b] && (free_preg_i[a] == free_preg_i[b])) begin
                    w_err_dup = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_err_fire | w_err_over | w_err_pass | w_err_dup) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    always @(posedge clk) begin
        if (!rst) begin
            a_fire_not_ready : assert (!w_err_fire);
            a_overflow       : assert (!w_err_over);
            a_commit_pass    : assert (!w_err_pass);
            a_double_free    : assert (!w_err_dup);
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_free_list
//  Purpose  : Self-checking bench for free_list (64 registers, 4-wide).
//             Vector table for the main paths, plus hand sequences for the
//             empty boundary, flush restore, long wrap run, async reset and
//             overflow error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

    localparam int W  = 4;
    localparam int PW = 6;
    localparam int N  = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [W-1:0]         alloc_req_i;
    logic                 alloc_fire_i;
    logic                 alloc_ready_o;
    logic [W-1:0][PW-1:0] preg_o;
    logic [W-1:0]         commit_dest_i;
    logic [W-1:0]         free_i;
    logic [W-1:0][PW-1:0] free_preg_i;
    logic                 restore_i;
    logic [PW:0]          free_cnt_o;
    logic                 err_o;

    free_list #(.PHY_REG_NUM(N), .ALLOC_WIDTH(W), .FREE_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req_i   (alloc_req_i),
        .alloc_fire_i  (alloc_fire_i),
        .alloc_ready_o (alloc_ready_o),
        .preg_o        (preg_o),
        .commit_dest_i (commit_dest_i),
        .free_i        (free_i),
        .free_preg_i   (free_preg_i),
        .restore_i     (restore_i),
        .free_cnt_o    (free_cnt_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Slot 0 first, packed into the port layout.
    function automatic logic [W-1:0][PW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
    endfunction

    typedef struct {
        logic [W-1:0]         req;
        logic                 fire;
        logic [W-1:0]         cdest;
        logic [W-1:0]         fr;
        logic [W-1:0][PW-1:0] fpreg;
        logic                 rest;
        logic                 exp_ready;
        logic [W-1:0]         pmask;
        logic [W-1:0][PW-1:0] exp_preg;
        logic [PW:0]          exp_cnt;   // free count after the edge
    } vec_t;

    vec_t vt[11];

    task automatic idle_inputs();
        alloc_req_i   = '0;
        alloc_fire_i  = 1'b0;
        commit_dest_i = '0;
        free_i        = '0;
        free_preg_i   = '0;
        restore_i     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int fq[$];
    int oq[$];
    int alloc_now[W];
    int freed_now[W];
    bit freeing;
    bit dup;

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_cnt",   free_cnt_o, 64);
        chk("reset_err",   err_o, 0);
        chk("reset_ready", alloc_ready_o, 1);

        // ---------------- vector table ----------------
        //          req     fire  cdest    fr       fpreg            rest  rdy  mask     exp_preg           cnt
        vt[0]  = '{4'hF, 1, 4'h0, 4'h0, pk(0,0,0,0), 0, 1, 4'hF, pk(0,1,2,3),   60};
        vt[1]  = '{4'hA, 1, 4'h0, 4'h0, pk(0,0,0,0), 0, 1, 4'hA, pk(0,4,0,5),   58};
        vt[2]  = '{4'h0, 0, 4'h0, 4'h3, pk(1,0,0,0), 0, 1, 4'h0, pk(0,0,0,0),   60};
        vt[3]  = '{4'h4, 1, 4'h0, 4'h4, pk(0,0,3,0), 0, 1, 4'h4, pk(0,0,6,0),   60};
        vt[4]  = '{4'hF, 0, 4'h0, 4'h0, pk(0,0,0,0), 0, 1, 4'hF, pk(7,8,9,10),  60};
        vt[5]  = '{4'h1, 1, 4'h7, 4'h0, pk(0,0,0,0), 1, 1, 4'h1, pk(7,0,0,0),   64};
        vt[6]  = '{4'hF, 1, 4'h0, 4'h0, pk(0,0,0,0), 0, 1, 4'hF, pk(3,4,5,6),   60};
        vt[7]  = '{4'h0, 0, 4'h0, 4'h9, pk(4,0,0,6), 0, 1, 4'h0, pk(0,0,0,0),   62};
        vt[8]  = '{4'h6, 0, 4'h0, 4'h0, pk(0,0,0,0), 0, 1, 4'h6, pk(0,7,8,0),   62};
        vt[9]  = '{4'h0, 1, 4'hF, 4'h0, pk(0,0,0,0), 1, 1, 4'h0, pk(0,0,0,0),   62};
        vt[10] = '{4'hF, 1, 4'h0, 4'h0, pk(0,0,0,0), 0, 1, 4'hF, pk(7,8,9,10),  58};

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            alloc_req_i   = vt[v].req;
            alloc_fire_i  = vt[v].fire;
            commit_dest_i = vt[v].cdest;
            free_i        = vt[v].fr;
            free_preg_i   = vt[v].fpreg;
            restore_i     = vt[v].rest;
            #1;
            chk($sformatf("v%0d_ready", v), alloc_ready_o, vt[v].exp_ready);
            for (int s = 0; s < W; s++) begin
                if (vt[v].pmask[s]) begin
                    chk($sformatf("v%0d_preg%0d", v, s), preg_o[s], vt[v].exp_preg[s]);
                end
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", v), free_cnt_o, vt[v].exp_cnt);
        end

        // ---------------- empty boundary ----------------
        do_reset();
        for (int g = 0; g < 16; g++) begin
            @(negedge clk);
            alloc_req_i  = 4'hF;
            alloc_fire_i = 1'b1;
            #1;
            chk($sformatf("drain%0d_p0", g), preg_o[0], 4 * g);
            chk($sformatf("drain%0d_p3", g), preg_o[3], 4 * g + 3);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("empty_cnt",        free_cnt_o, 0);
        chk("empty_ready_noreq", alloc_ready_o, 1);
        alloc_req_i = 4'h1;
        #1;
        chk("empty_ready_req", alloc_ready_o, 0);
        free_i      = 4'h1;
        free_preg_i = pk(5, 0, 0, 0);
        #1;
        chk("empty_no_bypass", alloc_ready_o, 0);
        @(negedge clk);
        free_i = '0;
        #1;
        chk("refill_ready", alloc_ready_o, 1);
        chk("refill_preg",  preg_o[0], 5);
        chk("refill_cnt",   free_cnt_o, 1);

        // ---------------- flush restore ----------------
        do_reset();
        repeat (2) begin
            @(negedge clk);
            alloc_req_i  = 4'hF;
            alloc_fire_i = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        commit_dest_i = 4'hF;
        @(negedge clk);
        idle_inputs();
        restore_i = 1'b1;
        @(posedge clk);
        #1;
        chk("restore_cnt", free_cnt_o, 60);
        @(negedge clk);
        idle_inputs();
        alloc_req_i = 4'h1;
        #1;
        chk("restore_preg", preg_o[0], 4);

        // ---------------- long wrap run ----------------
        do_reset();
        fq.delete();
        oq.delete();
        for (int i = 0; i < N; i++) fq.push_back(i);
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            idle_inputs();
            alloc_req_i  = 4'hF;
            alloc_fire_i = 1'b1;
            freeing = (oq.size() >= 8);
            if (freeing) begin
                free_i        = 4'hF;
                commit_dest_i = 4'hF;
                free_preg_i   = pk(oq[0], oq[1], oq[2], oq[3]);
            end
            #1;
            chk($sformatf("wrap%0d_ready", it), alloc_ready_o, 1);
            for (int s = 0; s < W; s++) begin
                chk($sformatf("wrap%0d_preg%0d", it, s), preg_o[s], fq[s]);
                dup = 1'b0;
                foreach (oq[j]) if (oq[j] == int'(preg_o[s])) dup = 1'b1;
                chk($sformatf("wrap%0d_unique%0d", it, s), dup, 0);
            end
            for (int s = 0; s < W; s++) alloc_now[s] = fq.pop_front();
            if (freeing) for (int s = 0; s < W; s++) freed_now[s] = oq.pop_front();
            for (int s = 0; s < W; s++) oq.push_back(alloc_now[s]);
            if (freeing) for (int s = 0; s < W; s++) fq.push_back(freed_now[s]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("wrap_cnt", free_cnt_o, fq.size());

        // ---------------- async reset mid-operation ----------------
        @(negedge clk);
        alloc_req_i  = 4'hF;
        alloc_fire_i = 1'b1;
        free_i       = 4'hF;
        free_preg_i  = pk(60, 61, 62, 63);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt",  free_cnt_o, 64);
        chk("arst_preg", preg_o[2], 2);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_hold_cnt", free_cnt_o, 64);

        // ---------------- free at full count ----------------
        @(negedge clk);
        idle_inputs();
        free_i      = 4'h1;
        free_preg_i = pk(0, 0, 0, 0);
        @(negedge clk);
        idle_inputs();
`ifdef FREELIST_CHECK_EN
        chk("err_set",  err_o, 1);
        @(negedge clk);
        chk("err_held", err_o, 1);
`else
        chk("err_tied", err_o, 0);
        @(negedge clk);
        chk("err_tied2", err_o, 0);
`endif
        do_reset();
        #1;
        chk("err_clear", err_o, 0);
        chk("final_cnt", free_cnt_o, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
